// File: rtl/sy_tl_a_arbiter.sv
// Round-robin arbiter sharing one TileLink A channel among HART_NUM harts; routes D back by source hart-ID.
// Latency: zero on A and D (pure combinational paths); only the arbitration state is registered.
// Backpressure: a stalled beat keeps its grant; Put bursts lock the grant; D ready follows the target hart.

package tl_pkg;
    localparam int SRC_W  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [3:0]          size;
        logic [SRC_W-1:0]    source;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W/8-1:0] mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } A_chan_bits_t;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [1:0]        param;
        logic [3:0]        size;
        logic [SRC_W-1:0]  source;
        logic [SRC_W-1:0]  sink;
        logic              denied;
        logic [DATA_W-1:0] data;
        logic              corrupt;
    } D_chan_bits_t;
endpackage

module sy_tl_a_arbiter
    import tl_pkg::*;
#(
    parameter int HART_NUM        = 2,
    parameter int HART_ID_WTH     = 1,
    parameter int HART_ID_LSB     = 1,
    parameter int BEAT_BYTES_LOG2 = 3,
    parameter int CNT_WTH         = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [HART_NUM-1:0]                inp_A_valid_i,
    output logic [HART_NUM-1:0]                inp_A_ready_o,
    input  tl_pkg::A_chan_bits_t [HART_NUM-1:0] inp_A_bits_i,
    output logic [HART_NUM-1:0]                inp_D_valid_o,
    input  logic [HART_NUM-1:0]                inp_D_ready_i,
    output tl_pkg::D_chan_bits_t [HART_NUM-1:0] inp_D_bits_o,
    output logic                               oup_A_valid_o,
    input  logic                               oup_A_ready_i,
    output tl_pkg::A_chan_bits_t               oup_A_bits_o,
    input  logic                               oup_D_valid_i,
    output logic                               oup_D_ready_o,
    input  tl_pkg::D_chan_bits_t               oup_D_bits_i,
    output logic                               route_err_o
);
    localparam int IDX_W = (HART_NUM > 1) ? $clog2(HART_NUM) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [CNT_WTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic                 hold_q, hold_d;
    logic                 route_err_q, route_err_d;

    logic [IDX_W-1:0]     scan_gnt;
    logic [IDX_W-1:0]     gnt;
    logic                 a_fire;
    logic [CNT_WTH-1:0]   beats_m1;
    logic [HART_ID_WTH-1:0] d_idx;
    logic                 d_in_range;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(HART_NUM - 1)) return '0;
        return v + 1'b1;
    endfunction

    // Round-robin scan: lowest offset from rr_ptr with a valid request wins.
    always_comb begin
        int idx;
        idx      = 0;
        scan_gnt = rr_ptr_q;
        for (int i = HART_NUM - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= HART_NUM) idx = idx - HART_NUM;
            if (inp_A_valid_i[idx]) scan_gnt = IDX_W'(idx);
        end
    end

    // A-channel mux: locked grant during a burst or a stalled offer, otherwise the scan result.
    always_comb begin
        gnt           = (state_q == BURST || hold_q) ? gnt_q : scan_gnt;
        oup_A_bits_o  = inp_A_bits_i[gnt];
        oup_A_valid_o = ~rst_i & ((state_q == BURST) ? inp_A_valid_i[gnt_q] : |inp_A_valid_i);
        inp_A_ready_o = '0;
        inp_A_ready_o[gnt] = oup_A_ready_i & ~rst_i;
        a_fire        = oup_A_valid_o & oup_A_ready_i;
        // Only Put messages larger than one bus beat span multiple beats.
        beats_m1      = '0;
        if ((oup_A_bits_o.opcode == 3'd0 || oup_A_bits_o.opcode == 3'd1) &&
            oup_A_bits_o.size > 4'(BEAT_BYTES_LOG2)) begin
            beats_m1 = (CNT_WTH'(1) << (oup_A_bits_o.size - 4'(BEAT_BYTES_LOG2))) - CNT_WTH'(1);
        end
    end

    // Arbitration next-state: hold on stall, lock for bursts, advance pointer past the winner.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE: begin
                if (oup_A_valid_o && !oup_A_ready_i) begin
                    gnt_d  = gnt;
                    hold_d = 1'b1;
                end else if (a_fire) begin
                    hold_d = 1'b0;
                    if (beats_m1 == '0) begin
                        rr_ptr_d = wrap_inc(gnt);
                    end else begin
                        gnt_d      = gnt;
                        beat_cnt_d = beats_m1;
                        state_d    = BURST;
                    end
                end
            end
            BURST: begin
                if (a_fire) begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == CNT_WTH'(1)) begin
                        rr_ptr_d = wrap_inc(gnt_q);
                        state_d  = IDLE;
                        hold_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // D routing by the hart-ID field of source; unroutable beats are swallowed and flagged.
    always_comb begin
        d_idx         = oup_D_bits_i.source[HART_ID_LSB +: HART_ID_WTH];
        d_in_range    = int'(d_idx) < HART_NUM;
        inp_D_valid_o = '0;
        oup_D_ready_o = ~rst_i;
        if (d_in_range) begin
            inp_D_valid_o[d_idx] = oup_D_valid_i & ~rst_i;
            oup_D_ready_o        = inp_D_ready_i[d_idx] & ~rst_i;
        end
        for (int h = 0; h < HART_NUM; h++) inp_D_bits_o[h] = oup_D_bits_i;
        route_err_d = route_err_q | (oup_D_valid_i & ~d_in_range);
        route_err_o = route_err_q;
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            beat_cnt_q  <= '0;
            hold_q      <= 1'b0;
            route_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            beat_cnt_q  <= beat_cnt_d;
            hold_q      <= hold_d;
            route_err_q <= route_err_d;
        end
    end
endmodule

// File: tb/tb_sy_tl_a_arbiter.sv
// Scoreboard bench for sy_tl_a_arbiter: per-hart request queues, expected grant order queue.
// Latency: checks A handshakes on the falling edge of the same cycle they occur.
// Backpressure: shared A ready and per-hart D ready are driven from the stimulus sequence.
module tb_sy_tl_a_arbiter;
    import tl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 2-hart DUT
    logic [1:0]               a_vld;
    logic [1:0]               a_rdy_o;
    A_chan_bits_t [1:0]       a_bits;
    logic [1:0]               d_vld_o;
    logic [1:0]               d_rdy;
    D_chan_bits_t [1:0]       d_bits_o;
    logic                     oa_vld;
    logic                     oa_rdy;
    A_chan_bits_t             oa_bits;
    logic                     od_vld;
    logic                     od_rdy;
    D_chan_bits_t             od_bits;
    logic                     err;

    // 3-hart DUT for out-of-range routing
    logic [2:0]               a3_vld;
    logic [2:0]               a3_rdy_o;
    A_chan_bits_t [2:0]       a3_bits;
    logic [2:0]               d3_vld_o;
    logic [2:0]               d3_rdy;
    D_chan_bits_t [2:0]       d3_bits_o;
    logic                     oa3_vld;
    logic                     oa3_rdy;
    A_chan_bits_t             oa3_bits;
    logic                     od3_vld;
    logic                     od3_rdy;
    D_chan_bits_t             od3_bits;
    logic                     err3;

    sy_tl_a_arbiter u_dut (
        .clk_i(clk), .rst_i(rst),
        .inp_A_valid_i(a_vld), .inp_A_ready_o(a_rdy_o), .inp_A_bits_i(a_bits),
        .inp_D_valid_o(d_vld_o), .inp_D_ready_i(d_rdy), .inp_D_bits_o(d_bits_o),
        .oup_A_valid_o(oa_vld), .oup_A_ready_i(oa_rdy), .oup_A_bits_o(oa_bits),
        .oup_D_valid_i(od_vld), .oup_D_ready_o(od_rdy), .oup_D_bits_i(od_bits),
        .route_err_o(err)
    );

    sy_tl_a_arbiter #(.HART_NUM(3), .HART_ID_WTH(2), .HART_ID_LSB(1)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .inp_A_valid_i(a3_vld), .inp_A_ready_o(a3_rdy_o), .inp_A_bits_i(a3_bits),
        .inp_D_valid_o(d3_vld_o), .inp_D_ready_i(d3_rdy), .inp_D_bits_o(d3_bits_o),
        .oup_A_valid_o(oa3_vld), .oup_A_ready_i(oa3_rdy), .oup_A_bits_o(oa3_bits),
        .oup_D_valid_i(od3_vld), .oup_D_ready_o(od3_rdy), .oup_D_bits_i(od3_bits),
        .route_err_o(err3)
    );

    typedef struct {
        int          hart;
        logic [31:0] addr;
    } exp_t;

    A_chan_bits_t hq0[$];
    A_chan_bits_t hq1[$];
    exp_t         sb[$];
    logic         fired0 = 1'b0;
    logic         fired1 = 1'b0;
    logic         a_rdy_drv = 1'b1;
    int           chk_cnt  = 0;
    int           pass_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] addr_of(input int hart, input int seq);
        return 32'(hart * 32'h1000 + seq);
    endfunction

    function automatic A_chan_bits_t mk(input int hart, input logic [2:0] op,
                                        input logic [3:0] size, input int seq);
        A_chan_bits_t b;
        b         = '0;
        b.opcode  = op;
        b.size    = size;
        b.source  = 4'(hart << 1);
        b.address = addr_of(hart, seq);
        b.mask    = 8'hff;
        b.data    = {32'hda7a0000, addr_of(hart, seq)};
        return b;
    endfunction

    task automatic req(input int hart, input logic [2:0] op, input logic [3:0] size, input int seq);
        if (hart == 0) hq0.push_back(mk(hart, op, size, seq));
        else           hq1.push_back(mk(hart, op, size, seq));
    endtask

    task automatic expect_beat(input int hart, input int seq);
        exp_t e;
        e.hart = hart;
        e.addr = addr_of(hart, seq);
        sb.push_back(e);
    endtask

    // One clock: retire last cycle's accepted heads, drive, then check at the falling edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (fired0) void'(hq0.pop_front());
        if (fired1) void'(hq1.pop_front());
        a_vld[0]  = hq0.size() != 0;
        a_vld[1]  = hq1.size() != 0;
        a_bits[0] = (hq0.size() != 0) ? hq0[0] : '0;
        a_bits[1] = (hq1.size() != 0) ? hq1[0] : '0;
        oa_rdy    = a_rdy_drv;
        @(negedge clk);
        fired0 = a_vld[0] & a_rdy_o[0];
        fired1 = a_vld[1] & a_rdy_o[1];
        if (oa_vld && oa_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 64'(oa_bits.address), 64'hffff_ffff);
            end else begin
                e = sb.pop_front();
                check("a_addr", 64'(oa_bits.address), 64'(e.addr));
                check("a_gnt_ready", 64'(a_rdy_o), 64'(2'b01 << e.hart));
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_vld = 2'b11; a_bits = '0; oa_rdy = 1'b1; d_rdy = 2'b11;
        od_vld = 1'b1; od_bits = '0;
        a3_vld = '0; a3_bits = '0; oa3_rdy = 1'b1; d3_rdy = 3'b111;
        od3_vld = 1'b0; od3_bits = '0;

        // Reset: every valid/ready output low while rst is high.
        #12;
        check("rst_oa_vld", 64'(oa_vld), 64'd0);
        check("rst_a_rdy", 64'(a_rdy_o), 64'd0);
        check("rst_d_vld", 64'(d_vld_o), 64'd0);
        check("rst_od_rdy", 64'(od_rdy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0; a_vld = '0; od_vld = 1'b0;

        // Two harts of Gets alternate starting from hart0.
        for (int i = 0; i < 4; i++) req(0, 3'd4, 4'd3, i);
        for (int i = 0; i < 3; i++) req(1, 3'd4, 4'd3, i);
        for (int i = 0; i < 3; i++) begin
            expect_beat(0, i);
            expect_beat(1, i);
        end
        expect_beat(0, 3);
        drain(30);

        // Pointer now at hart1: its 8-beat Put locks out hart0 for the whole burst.
        for (int i = 10; i < 18; i++) req(1, 3'd0, 4'd6, i);
        req(0, 3'd4, 4'd3, 10);
        req(0, 3'd4, 4'd3, 11);
        for (int i = 10; i < 18; i++) expect_beat(1, i);
        expect_beat(0, 10);
        expect_beat(0, 11);
        drain(40);

        // Stalled hart0 offer keeps its grant while hart1 (favoured by rr) joins.
        a_rdy_drv = 1'b0;
        req(0, 3'd4, 4'd3, 20);
        cycle();
        check("stall_bits_c0", 64'(oa_bits.address), 64'(addr_of(0, 20)));
        req(1, 3'd4, 4'd3, 20);
        cycle();
        check("stall_bits_c1", 64'(oa_bits.address), 64'(addr_of(0, 20)));
        check("stall_rdy_c1", 64'(a_rdy_o), 64'd0);
        cycle();
        check("stall_bits_c2", 64'(oa_bits.address), 64'(addr_of(0, 20)));
        a_rdy_drv = 1'b1;
        expect_beat(0, 20);
        expect_beat(1, 20);
        drain(20);

        // D routing to hart1 with backpressure, then to hart0.
        od_bits        = '0;
        od_bits.source = 4'b0010;
        od_bits.data   = 64'hfeed_beef_0000_0001;
        od_vld         = 1'b1;
        d_rdy          = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("d_vld_h1", 64'(d_vld_o), 64'd2);
            check("d_rdy_stall", 64'(od_rdy), 64'd0);
        end
        d_rdy = 2'b11;
        #1;
        check("d_rdy_go", 64'(od_rdy), 64'd1);
        check("d_bcast", d_bits_o[0].data, 64'hfeed_beef_0000_0001);
        od_bits.source = 4'b0000;
        #1;
        check("d_vld_h0", 64'(d_vld_o), 64'd1);
        @(negedge clk);
        od_vld = 1'b0;

        // Three-hart instance: hart-ID 2 routes, hart-ID 3 is dropped and flags a sticky error.
        od3_bits        = '0;
        od3_bits.source = 4'b0100;
        od3_vld         = 1'b1;
        #1;
        check("d3_vld_h2", 64'(d3_vld_o), 64'd4);
        check("d3_err_clear", 64'(err3), 64'd0);
        od3_bits.source = 4'b0110;
        #1;
        check("d3_drop_rdy", 64'(od3_rdy), 64'd1);
        check("d3_drop_vld", 64'(d3_vld_o), 64'd0);
        @(posedge clk);
        #1;
        od3_vld = 1'b0;
        @(negedge clk);
        check("d3_err_set", 64'(err3), 64'd1);
        @(negedge clk);
        check("d3_err_sticky", 64'(err3), 64'd1);

        // Reset during the 4th beat of an 8-beat burst.
        for (int i = 30; i < 38; i++) req(1, 3'd0, 4'd6, i);
        for (int i = 30; i < 33; i++) expect_beat(1, i);
        for (int i = 0; i < 3; i++) cycle();
        @(posedge clk);
        #1;
        od_bits.source = 4'b0000;
        od_vld = 1'b1;
        a_vld  = 2'b10;
        a_bits[1] = mk(1, 3'd0, 4'd6, 33);
        rst    = 1'b1;
        #1;
        check("mid_rst_oa_vld", 64'(oa_vld), 64'd0);
        check("mid_rst_a_rdy", 64'(a_rdy_o), 64'd0);
        check("mid_rst_d_vld", 64'(d_vld_o), 64'd0);
        check("mid_rst_od_rdy", 64'(od_rdy), 64'd0);
        hq0.delete();
        hq1.delete();
        fired0 = 1'b0;
        fired1 = 1'b0;
        od_vld = 1'b0;
        a_vld  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req(0, 3'd4, 4'd3, 40);
        req(1, 3'd4, 4'd3, 40);
        expect_beat(0, 40);
        expect_beat(1, 40);
        drain(20);

        // Single-beat PutFullData (size equals bus width) must not lock the grant.
        req(0, 3'd0, 4'd3, 50);
        req(0, 3'd4, 4'd3, 51);
        req(1, 3'd4, 4'd3, 50);
        expect_beat(0, 50);
        expect_beat(1, 50);
        expect_beat(0, 51);
        drain(20);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
